// File: rtl/adpll_pkg.sv
// adpll_pkg: shared definitions for the ADPLL lock monitor.
//   state_e      monitor state (IDLE / ARM / MEAS)
//   M_W          width of the ADPLL multiplication factor
//   DEF_*        default window length, tolerance and confirm count
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

  localparam int M_W          = 3;
  localparam int DEF_WIN_LOG2 = 3;
  localparam int DEF_TOL      = 1;
  localparam int DEF_CONFIRM  = 4;

endpackage

// File: rtl/adpll_lock_monitor_if.sv
// adpll_lock_monitor_if: ADPLL output pins observed by the monitor plus the
// monitor's status outputs.
//   master : ADPLL / stimulus side, drives ref_clk, out_clk, m, lock, polarity
//   slave  : lock monitor, drives meas_cnt, meas_valid, freq_ok,
//            lock_confirmed, lock_err (and pol_toggles when the
//            POL_TOGGLE_CNT_EN macro is defined)
interface adpll_lock_monitor_if #(
  parameter int CNT_W = 8
);
  import adpll_pkg::*;

  logic             ref_clk;
  logic             out_clk;
  logic [M_W-1:0]   m;
  logic             lock;
  logic             polarity;
  logic [CNT_W-1:0] meas_cnt;
  logic             meas_valid;
  logic             freq_ok;
  logic             lock_confirmed;
  logic             lock_err;
`ifdef POL_TOGGLE_CNT_EN
  logic [CNT_W-1:0] pol_toggles;
`endif

  modport master (
    output ref_clk, out_clk, m, lock, polarity,
    input  meas_cnt, meas_valid, freq_ok, lock_confirmed, lock_err
`ifdef POL_TOGGLE_CNT_EN
    , input pol_toggles
`endif
  );

  modport slave (
    input  ref_clk, out_clk, m, lock, polarity,
    output meas_cnt, meas_valid, freq_ok, lock_confirmed, lock_err
`ifdef POL_TOGGLE_CNT_EN
    , output pol_toggles
`endif
  );

endinterface

// File: rtl/adpll_sync_edge.sv
// adpll_sync_edge: 2-flop synchronizer for an asynchronous pin followed by one
// history flop for edge detection.
//   i_clk, i_rst_n : sampling clock, synchronous active-low reset
//   i_d            : asynchronous input
//   o_level        : synchronized level
//   o_rise         : one-cycle pulse on a synchronized rising edge
//   o_edge         : one-cycle pulse on any synchronized transition
module adpll_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_edge
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;
  assign o_edge  = r_s2 ^ r_s3;

endmodule

// File: rtl/adpll_lock_monitor.sv
// adpll_lock_monitor: counts ADPLL OUT_CLK rising edges over 2^WIN_LOG2
// REF_CLK periods and compares against M << WIN_LOG2.
//   i_clk   : sampling clock (>= 4x OUT_CLK)
//   i_rst_n : synchronous active-low reset
//   i_en    : monitor enable
//   mon     : slave side of adpll_lock_monitor_if (pins in, status out)
// Optional: define POL_TOGGLE_CNT_EN to add the POLARITY transition counter
// (mon.pol_toggles); without it POLARITY is ignored.
module adpll_lock_monitor
  import adpll_pkg::*;
#(
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  parameter int TOL      = DEF_TOL,
  parameter int CONFIRM  = DEF_CONFIRM,
  parameter int CNT_W    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  adpll_lock_monitor_if.slave  mon
);

  localparam int SY_REF = 0;
  localparam int SY_OUT = 1;
  localparam int SY_LCK = 2;
  localparam int SY_POL = 3;

  // ---- pin synchronizers -------------------------------------------------
  logic [3:0] w_pin, w_lvl, w_rise, w_edge;
  assign w_pin = {mon.polarity, mon.lock, mon.out_clk, mon.ref_clk};

  for (genvar g = 0; g < 4; g++) begin : g_sync
    adpll_sync_edge u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (w_pin[g]),
      .o_level (w_lvl[g]),
      .o_rise  (w_rise[g]),
      .o_edge  (w_edge[g])
    );
  end

  logic w_ref_rise, w_out_rise, w_lock_s;
  assign w_ref_rise = w_rise[SY_REF];
  assign w_out_rise = w_rise[SY_OUT];
  assign w_lock_s   = w_lvl[SY_LCK];

  // ---- state ---------------------------------------------------------------
  state_e                r_state, w_state_nxt;
  logic [WIN_LOG2-1:0]   r_ref_cnt;
  logic [CNT_W-1:0]      r_out_cnt;
  logic [M_W-1:0]        r_m_win;
  logic [3:0]            r_good;
  logic [CNT_W-1:0]      r_meas_cnt;
  logic                  r_meas_valid, r_freq_ok, r_lock_conf, r_lock_err;

  // M moving under an open window invalidates it
  logic w_m_chg;
  assign w_m_chg = (r_state == MEAS) && (mon.m != r_m_win);

  // closing edge is the 2^WIN_LOG2-th REF rise after the opening one
  logic w_win_end;
  assign w_win_end = (r_state == MEAS) && i_en && !w_m_chg && w_ref_rise &&
                     (r_ref_cnt == '1);

  // OUT count including an edge seen in this cycle, saturating
  logic [CNT_W-1:0] w_out_nxt;
  assign w_out_nxt = (w_out_rise && (r_out_cnt != '1)) ? r_out_cnt + CNT_W'(1)
                                                        : r_out_cnt;

  // one extra bit so expected never wraps and |diff| is exact
  logic [CNT_W:0] w_exp, w_cnt_x, w_diff;
  logic           w_win_ok;
  assign w_exp    = (CNT_W+1)'(r_m_win) << WIN_LOG2;
  assign w_cnt_x  = {1'b0, w_out_nxt};
  assign w_diff   = (w_cnt_x >= w_exp) ? (w_cnt_x - w_exp) : (w_exp - w_cnt_x);
  assign w_win_ok = (r_m_win != '0) && (w_diff <= (CNT_W+1)'(TOL));

  logic [3:0] w_good_nxt;
  assign w_good_nxt = (r_good == 4'(CONFIRM)) ? r_good : r_good + 4'd1;

  // ---- FSM -----------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_en) w_state_nxt = ARM;
      ARM:     if (!i_en) w_state_nxt = IDLE;
               else if (w_ref_rise) w_state_nxt = MEAS;
      MEAS:    if (!i_en) w_state_nxt = IDLE;
               else if (w_m_chg) w_state_nxt = ARM;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- window datapath -----------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ref_cnt    <= '0;
      r_out_cnt    <= '0;
      r_m_win      <= '0;
      r_good       <= '0;
      r_meas_cnt   <= '0;
      r_meas_valid <= 1'b0;
      r_freq_ok    <= 1'b0;
      r_lock_conf  <= 1'b0;
      r_lock_err   <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      if (!i_en) begin
        // MEAS_CNT and LOCK_ERR deliberately hold across disable
        r_ref_cnt   <= '0;
        r_out_cnt   <= '0;
        r_good      <= '0;
        r_freq_ok   <= 1'b0;
        r_lock_conf <= 1'b0;
      end else begin
        if (r_state == IDLE) r_lock_err <= 1'b0;
        if (r_state == ARM && w_ref_rise) begin
          r_ref_cnt <= '0;
          r_out_cnt <= '0;
          r_m_win   <= mon.m;
        end
        if (r_state == MEAS && !w_m_chg) begin
          if (w_win_end) begin
            // closing edge also opens the next window
            r_ref_cnt    <= '0;
            r_out_cnt    <= '0;
            r_m_win      <= mon.m;
            r_meas_cnt   <= w_out_nxt;
            r_meas_valid <= 1'b1;
            r_freq_ok    <= w_win_ok;
            if (w_win_ok) begin
              r_good      <= w_good_nxt;
              r_lock_conf <= (w_good_nxt == 4'(CONFIRM));
            end else begin
              r_good      <= '0;
              r_lock_conf <= 1'b0;
              if ((r_m_win != '0) && w_lock_s) r_lock_err <= 1'b1;
            end
          end else begin
            if (w_ref_rise) r_ref_cnt <= r_ref_cnt + WIN_LOG2'(1);
            r_out_cnt <= w_out_nxt;
          end
        end
      end
    end
  end

  assign mon.meas_cnt       = r_meas_cnt;
  assign mon.meas_valid     = r_meas_valid;
  assign mon.freq_ok        = r_freq_ok;
  assign mon.lock_confirmed = r_lock_conf;
  assign mon.lock_err       = r_lock_err;

  // ---- optional POLARITY transition counter --------------------------------
`ifdef POL_TOGGLE_CNT_EN
  logic [CNT_W-1:0] r_pol_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en)
      r_pol_cnt <= '0;
    else if (r_state == MEAS && w_edge[SY_POL] && (r_pol_cnt != '1))
      r_pol_cnt <= r_pol_cnt + CNT_W'(1);
  end

  assign mon.pol_toggles = r_pol_cnt;

  logic w_unused_sync;
  assign w_unused_sync = ^{w_lvl[SY_REF], w_lvl[SY_OUT], w_lvl[SY_POL],
                           w_rise[SY_LCK], w_rise[SY_POL],
                           w_edge[SY_REF], w_edge[SY_OUT], w_edge[SY_LCK]};
`else
  logic w_unused_sync;
  assign w_unused_sync = ^{w_lvl[SY_REF], w_lvl[SY_OUT], w_lvl[SY_POL],
                           w_rise[SY_LCK], w_rise[SY_POL],
                           w_edge[SY_REF], w_edge[SY_OUT], w_edge[SY_LCK],
                           w_edge[SY_POL]};
`endif

endmodule
